// File: rtl/i2c_pad_ctrl.sv
// Open-drain I2C pad conditioning for NUM_CH independent buses: synchronise and
// deglitch SDA/SCL, flag START/STOP, track busy, arbitration loss and stretching.

module i2c_line_filt #(
  parameter int SYNC_STG = 2,
  parameter int FILT_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pad,
  output logic filt
);
  localparam int CW = $clog2(FILT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STG-1:0] sync_r;
  logic                sync_s;
  logic                filt_r;
  logic                filt_nxt_s;
  logic [CW-1:0]       cnt_r;
  logic [CW-1:0]       cnt_nxt_s;

  assign sync_s = sync_r[SYNC_STG-1];
  assign filt   = filt_r;

  // Synchroniser chain; resets high so a released bus looks idle immediately.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_r <= {SYNC_STG{1'b1}};
    end else begin
      sync_r <= {sync_r[SYNC_STG-2:0], pad};
    end
  end

  // A new level is accepted only after FILT_CYC consecutive disagreeing samples.
  always_comb begin
    filt_nxt_s = filt_r;
    cnt_nxt_s  = {CW{1'b0}};
    if (sync_s == filt_r) begin
      cnt_nxt_s = {CW{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      filt_nxt_s = sync_s;
      cnt_nxt_s  = {CW{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Filter state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      filt_r <= 1'b1;
      cnt_r  <= {CW{1'b0}};
    end else begin
      filt_r <= filt_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end
endmodule

module i2c_pad_ctrl_chk #(
  parameter int NUM_CH = 2
) (
  input logic              clk,
  input logic              reset,
  input logic [NUM_CH-1:0] start_det,
  input logic [NUM_CH-1:0] stop_det,
  input logic [NUM_CH-1:0] bus_busy,
  input logic [NUM_CH-1:0] arb_lost,
  input logic [NUM_CH-1:0] arb_clr
);
  for (genvar k = 0; k < NUM_CH; k++) begin : g_chk
    a_no_start_and_stop : assert property (@(posedge clk) disable iff (!reset)
      !(start_det[k] && stop_det[k]));
    a_busy_rises_on_start : assert property (@(posedge clk) disable iff (!reset)
      $rose(bus_busy[k]) |-> start_det[k]);
    a_arb_sticky : assert property (@(posedge clk) disable iff (!reset)
      (arb_lost[k] && !arb_clr[k]) |=> arb_lost[k]);
  end
endmodule

module i2c_pad_ctrl #(
  parameter int NUM_CH   = 2,
  parameter int SYNC_STG = 2,
  parameter int FILT_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  inout  wire  [NUM_CH-1:0] sda,
  inout  wire  [NUM_CH-1:0] scl,
  input  logic [NUM_CH-1:0] sda_o,
  input  logic [NUM_CH-1:0] scl_o,
  output logic [NUM_CH-1:0] sda_i,
  output logic [NUM_CH-1:0] scl_i,
  output logic [NUM_CH-1:0] start_det,
  output logic [NUM_CH-1:0] stop_det,
  output logic [NUM_CH-1:0] bus_busy,
  output logic [NUM_CH-1:0] arb_lost,
  input  logic [NUM_CH-1:0] arb_clr,
  output logic [NUM_CH-1:0] stretch
);
  localparam int DLY = SYNC_STG + FILT_CYC;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic           sda_filt_s;
    logic           scl_filt_s;
    logic [DLY-1:0] sda_dly_r;
    logic [DLY-1:0] scl_dly_r;
    logic           sda_od_s;
    logic           scl_od_s;
    logic           sda_q_r;
    logic           scl_q_r;
    logic           start_s;
    logic           stop_s;
    logic           arb_set_s;
    logic           stretch_s;
    logic           busy_nxt_s;
    logic           arb_nxt_s;
    logic           start_det_r;
    logic           stop_det_r;
    logic           bus_busy_r;
    logic           arb_lost_r;
    logic           stretch_r;

    // Open-drain: only ever pull low, never drive high, regardless of reset.
    assign sda[k] = sda_o[k] ? 1'bz : 1'b0;
    assign scl[k] = scl_o[k] ? 1'bz : 1'b0;

    i2c_line_filt #(.SYNC_STG(SYNC_STG), .FILT_CYC(FILT_CYC)) u_sda_filt (
      .clk   (clk),
      .reset (reset),
      .pad   (sda[k]),
      .filt  (sda_filt_s)
    );

    i2c_line_filt #(.SYNC_STG(SYNC_STG), .FILT_CYC(FILT_CYC)) u_scl_filt (
      .clk   (clk),
      .reset (reset),
      .pad   (scl[k]),
      .filt  (scl_filt_s)
    );

    assign sda_od_s = sda_dly_r[DLY-1];
    assign scl_od_s = scl_dly_r[DLY-1];

    // Delay the core's drive values so they line up with the filtered pad levels.
    always_ff @(posedge clk) begin
      if (!reset) begin
        sda_dly_r <= {DLY{1'b1}};
        scl_dly_r <= {DLY{1'b1}};
      end else begin
        sda_dly_r <= {sda_dly_r[DLY-2:0], sda_o[k]};
        scl_dly_r <= {scl_dly_r[DLY-2:0], scl_o[k]};
      end
    end

    // Previous filtered levels for edge detection.
    always_ff @(posedge clk) begin
      if (!reset) begin
        sda_q_r <= 1'b1;
        scl_q_r <= 1'b1;
      end else begin
        sda_q_r <= sda_filt_s;
        scl_q_r <= scl_filt_s;
      end
    end

    // Bus conditions; SCL must be stable high across the SDA edge to count.
    always_comb begin
      start_s   = sda_q_r & ~sda_filt_s & scl_q_r & scl_filt_s;
      stop_s    = ~sda_q_r & sda_filt_s & scl_q_r & scl_filt_s;
      arb_set_s = ~scl_q_r & scl_filt_s & bus_busy_r & sda_od_s & ~sda_filt_s;
      stretch_s = scl_od_s & ~scl_filt_s;
      if (start_s) begin
        busy_nxt_s = 1'b1;
      end else if (stop_s) begin
        busy_nxt_s = 1'b0;
      end else begin
        busy_nxt_s = bus_busy_r;
      end
      if (arb_set_s) begin
        arb_nxt_s = 1'b1;
      end else if (arb_clr[k]) begin
        arb_nxt_s = 1'b0;
      end else begin
        arb_nxt_s = arb_lost_r;
      end
    end

    // Registered status flags.
    always_ff @(posedge clk) begin
      if (!reset) begin
        start_det_r <= 1'b0;
        stop_det_r  <= 1'b0;
        bus_busy_r  <= 1'b0;
        arb_lost_r  <= 1'b0;
        stretch_r   <= 1'b0;
      end else begin
        start_det_r <= start_s;
        stop_det_r  <= stop_s;
        bus_busy_r  <= busy_nxt_s;
        arb_lost_r  <= arb_nxt_s;
        stretch_r   <= stretch_s;
      end
    end

    assign sda_i[k]     = sda_filt_s;
    assign scl_i[k]     = scl_filt_s;
    assign start_det[k] = start_det_r;
    assign stop_det[k]  = stop_det_r;
    assign bus_busy[k]  = bus_busy_r;
    assign arb_lost[k]  = arb_lost_r;
    assign stretch[k]   = stretch_r;
  end

  i2c_pad_ctrl_chk #(.NUM_CH(NUM_CH)) u_chk (
    .clk       (clk),
    .reset     (reset),
    .start_det (start_det),
    .stop_det  (stop_det),
    .bus_busy  (bus_busy),
    .arb_lost  (arb_lost),
    .arb_clr   (arb_clr)
  );
endmodule

// File: tb/tb_i2c_pad_ctrl.sv
// Bench for i2c_pad_ctrl: vector table with a scoreboard queue, plus timed
// sequences for filter latency, arbitration races, stretching and reset.

module tb_i2c_pad_ctrl;
  localparam int NUM_CH   = 2;
  localparam int SYNC_STG = 2;
  localparam int FILT_CYC = 4;
  localparam int DLY      = SYNC_STG + FILT_CYC;

  logic              clk = 1'b0;
  logic              reset;
  wire  [NUM_CH-1:0] sda;
  wire  [NUM_CH-1:0] scl;
  logic [NUM_CH-1:0] sda_o, scl_o, arb_clr, ext_sda, ext_scl;
  logic [NUM_CH-1:0] sda_i, scl_i, start_det, stop_det, bus_busy, arb_lost, stretch;

  always #5 clk = ~clk;

  // Pull-ups plus an external open-drain device on every line.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_bus
    pullup (sda[k]);
    pullup (scl[k]);
    assign sda[k] = ext_sda[k] ? 1'b0 : 1'bz;
    assign scl[k] = ext_scl[k] ? 1'b0 : 1'bz;
  end

  i2c_pad_ctrl #(.NUM_CH(NUM_CH), .SYNC_STG(SYNC_STG), .FILT_CYC(FILT_CYC)) dut (
    .clk       (clk),
    .reset     (reset),
    .sda       (sda),
    .scl       (scl),
    .sda_o     (sda_o),
    .scl_o     (scl_o),
    .sda_i     (sda_i),
    .scl_i     (scl_i),
    .start_det (start_det),
    .stop_det  (stop_det),
    .bus_busy  (bus_busy),
    .arb_lost  (arb_lost),
    .arb_clr   (arb_clr),
    .stretch   (stretch)
  );

  typedef struct {
    string      name;
    logic [1:0] so, co, es, ec, clr;
    int         cyc;
    logic [1:0] x_sda, x_scl, x_busy, x_arb, x_str, x_st, x_sp;
  } vec_t;

  typedef struct {
    string      name;
    logic [1:0] sda, scl, busy, arb, str, st, sp;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   st_cnt [NUM_CH] = '{default: 0};
  int   sp_cnt [NUM_CH] = '{default: 0};
  int   st_base [NUM_CH];
  int   sp_base [NUM_CH];

  // Pulse counters for the single-cycle START/STOP flags.
  always @(negedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (start_det[k] === 1'b1) st_cnt[k]++;
      if (stop_det[k] === 1'b1) sp_cnt[k]++;
    end
  end

  task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_n(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mark();
    st_base = st_cnt;
    sp_base = sp_cnt;
  endtask

  task automatic add(input string nm, input logic [1:0] so, co, es, ec, clr, input int cyc,
                     input logic [1:0] x_sda, x_scl, x_busy, x_arb, x_str, x_st, x_sp);
    vec_t v;
    v.name = nm; v.so = so; v.co = co; v.es = es; v.ec = ec; v.clr = clr; v.cyc = cyc;
    v.x_sda = x_sda; v.x_scl = x_scl; v.x_busy = x_busy; v.x_arb = x_arb;
    v.x_str = x_str; v.x_st = x_st; v.x_sp = x_sp;
    vecs.push_back(v);
  endtask

  initial begin
    exp_t e;
    exp_t got;
    //   name           so     co     es     ec     clr  cyc  sda_i  scl_i  busy   arb    str    start  stop
    add("idle",        2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 10, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add("start_ch0",   2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 10, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00);
    add("scl_low_ch0", 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 10, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    add("sda_rel_ch0", 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 10, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    add("ext_sda_ch0", 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 10, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    add("arb_loss_ch0",2'b11, 2'b11, 2'b01, 2'b00, 2'b00, 10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    add("arb_clr_ch0", 2'b11, 2'b11, 2'b01, 2'b00, 2'b01, 10, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    add("stop_ch0",    2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 10, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
    add("start_ch1",   2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 10, 2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00);
    add("scl_low_ch1", 2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 10, 2'b01, 2'b01, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00);
    add("sda_hi_ch1",  2'b11, 2'b11, 2'b00, 2'b10, 2'b00, 10, 2'b11, 2'b01, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00);
    add("scl_hi_ch1",  2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 10, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
    add("rstart_ch1",  2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 10, 2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00);
    add("same_cyc_p",  2'b11, 2'b11, 2'b00, 2'b10, 2'b00, 10, 2'b11, 2'b01, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00);
    add("same_cyc_s",  2'b11, 2'b11, 2'b10, 2'b00, 2'b00, 10, 2'b01, 2'b11, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
    add("stop_ch1",    2'b11, 2'b11, 2'b00, 2'b00, 2'b10, 10, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);
    add("stretch_ch0", 2'b11, 2'b11, 2'b00, 2'b01, 2'b00, 10, 2'b11, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    add("release",     2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 10, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

    // Reset with ch0 pulling SDA: the pad follows the core immediately.
    reset = 1'b0; sda_o = 2'b10; scl_o = 2'b11; arb_clr = 2'b00; ext_sda = 2'b00; ext_scl = 2'b00;
    #1;
    chk("pad_sda_in_reset", sda, 2'b10);
    chk("pad_scl_in_reset", scl, 2'b11);
    cycles(3);
    chk("rst sda_i", sda_i, 2'b11);
    chk("rst scl_i", scl_i, 2'b11);
    chk("rst start_det", start_det, 2'b00);
    chk("rst stop_det", stop_det, 2'b00);
    chk("rst bus_busy", bus_busy, 2'b00);
    chk("rst arb_lost", arb_lost, 2'b00);
    chk("rst stretch", stretch, 2'b00);
    sda_o = 2'b11;
    #1;
    chk("pad_sda_released", sda, 2'b11);
    reset = 1'b1;
    cycles(10);
    chk("idle sda_i", sda_i, 2'b11);

    // 3-cycle low pulse on ch1 SDA is rejected.
    mark();
    ext_sda[1] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 3) ext_sda[1] = 1'b0;
      chk($sformatf("glitch3 sda_i c%0d", c), sda_i, 2'b11);
    end
    chk_n("glitch3 start pulses", st_cnt[1] - st_base[1], 0);

    // 4-cycle low pulse passes with exactly DLY cycles of latency each way.
    mark();
    ext_sda[1] = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 4) ext_sda[1] = 1'b0;
      chk($sformatf("glitch4 sda_i c%0d", c), sda_i, (c >= DLY && c < 4 + DLY) ? 2'b01 : 2'b11);
      if (c == 8) chk("glitch4 busy", bus_busy, 2'b10);
    end
    chk_n("glitch4 start pulses", st_cnt[1] - st_base[1], 1);
    chk_n("glitch4 stop pulses", sp_cnt[1] - sp_base[1], 1);
    chk("glitch4 busy end", bus_busy, 2'b00);

    // Vector table through the scoreboard.
    foreach (vecs[i]) begin
      sda_o = vecs[i].so; scl_o = vecs[i].co; ext_sda = vecs[i].es;
      ext_scl = vecs[i].ec; arb_clr = vecs[i].clr;
      e.name = vecs[i].name; e.sda = vecs[i].x_sda; e.scl = vecs[i].x_scl;
      e.busy = vecs[i].x_busy; e.arb = vecs[i].x_arb; e.str = vecs[i].x_str;
      e.st = vecs[i].x_st; e.sp = vecs[i].x_sp;
      sb.push_back(e);
      mark();
      cycles(vecs[i].cyc);
      got = sb.pop_front();
      chk({got.name, " sda_i"}, sda_i, got.sda);
      chk({got.name, " scl_i"}, scl_i, got.scl);
      chk({got.name, " bus_busy"}, bus_busy, got.busy);
      chk({got.name, " arb_lost"}, arb_lost, got.arb);
      chk({got.name, " stretch"}, stretch, got.str);
      for (int k = 0; k < NUM_CH; k++) begin
        chk_n($sformatf("%s start[%0d]", got.name, k), st_cnt[k] - st_base[k], int'(got.st[k]));
        chk_n($sformatf("%s stop[%0d]", got.name, k), sp_cnt[k] - sp_base[k], int'(got.sp[k]));
      end
    end
    arb_clr = 2'b00;

    // arb_clr coinciding with a new loss: set wins, flag survives STOP.
    sda_o = 2'b10; cycles(10);
    chk("race busy", bus_busy, 2'b01);
    scl_o = 2'b10; cycles(10);
    sda_o = 2'b11; ext_sda = 2'b01; cycles(10);
    scl_o = 2'b11;
    cycles(DLY);
    chk("race scl_i rise", scl_i, 2'b11);
    chk("race arb before", arb_lost, 2'b00);
    arb_clr = 2'b01;
    cycles(1);
    arb_clr = 2'b00;
    chk("race set beats clr", arb_lost, 2'b01);
    cycles(5);
    chk("race arb held", arb_lost, 2'b01);
    ext_sda = 2'b00; cycles(10);
    chk("race busy after stop", bus_busy, 2'b00);
    chk("race arb across stop", arb_lost, 2'b01);
    arb_clr = 2'b01; cycles(1); arb_clr = 2'b00;
    chk("race arb cleared", arb_lost, 2'b00);

    // Clock stretch on ch0: external device holds SCL 20 cycles after core release.
    scl_o = 2'b10; cycles(10);
    ext_scl = 2'b01; cycles(4);
    scl_o = 2'b11;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 20) ext_scl[0] = 1'b0;
      chk($sformatf("stretch c%0d", c), stretch, (c >= DLY + 1 && c < 20 + DLY + 1) ? 2'b01 : 2'b00);
    end

    // Reset in the middle of a ch1 transfer: busy stays low until a fresh START.
    ext_sda = 2'b10; cycles(10);
    chk("mid busy before", bus_busy, 2'b10);
    ext_scl = 2'b10; cycles(10);
    reset = 1'b0; cycles(2);
    chk("mid busy in reset", bus_busy, 2'b00);
    reset = 1'b1;
    mark();
    cycles(12);
    chk("mid busy after", bus_busy, 2'b00);
    chk("mid sda_i", sda_i, 2'b01);
    chk("mid scl_i", scl_i, 2'b01);
    chk_n("mid no start", st_cnt[1] - st_base[1], 0);
    ext_scl = 2'b00; cycles(10);
    chk("mid busy scl up", bus_busy, 2'b00);
    chk_n("mid no start scl up", st_cnt[1] - st_base[1], 0);
    ext_sda = 2'b00; cycles(10);
    chk("mid busy after stop", bus_busy, 2'b00);
    mark();
    ext_sda = 2'b10; cycles(10);
    chk("mid busy new start", bus_busy, 2'b10);
    chk_n("mid new start pulse", st_cnt[1] - st_base[1], 1);
    chk_n("mid ch0 untouched", st_cnt[0] - st_base[0], 0);
    ext_sda = 2'b00; cycles(10);
    chk("mid busy end", bus_busy, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/i2c_pad_ctrl.md
Name: i2c_pad_ctrl

Overview:
- Multi-channel open-drain I2C pad interface with conditioning for NUM_CH independent I2C buses.
- Per channel: open-drain SDA/SCL drive, input synchronisation, digital glitch filtering, START/STOP detection, bus-busy tracking, arbitration-loss detection and clock-stretch indication.
- Sits between the I2C master core(s) and the top-level pads, replacing the bare tristate assignments.

Parameters:
- NUM_CH, 2: number of independent I2C channels.
- SYNC_STG, 2: synchroniser flops per input line, minimum 2.
- FILT_CYC, 4: consecutive stable clk cycles needed before a filtered line changes, minimum 1.
- DLY: derived localparam, not user-set, equal to SYNC_STG+FILT_CYC. Latency used to align drive values with filtered values.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-low.
- sda  inout  NUM_CH  SDA pads, open-drain.
- scl  inout  NUM_CH  SCL pads, open-drain.
- sda_o  in  NUM_CH  core SDA drive: 1 = release (Z), 0 = pull low.
- scl_o  in  NUM_CH  core SCL drive: 1 = release (Z), 0 = pull low.
- sda_i  out  NUM_CH  filtered SDA level.
- scl_i  out  NUM_CH  filtered SCL level.
- start_det  out  NUM_CH  one-cycle pulse on START or repeated START.
- stop_det  out  NUM_CH  one-cycle pulse on STOP.
- bus_busy  out  NUM_CH  high from START until STOP.
- arb_lost  out  NUM_CH  sticky arbitration-loss flag.
- arb_clr  in  NUM_CH  clears arb_lost for that channel.
- stretch  out  NUM_CH  high while SCL is held low by another device.

Behaviour:
- Pad drive is combinational and independent of reset: sda[k] = sda_o[k] ? Z : 0; same rule for scl[k].
- Reset (reset=0 at a clk edge):
  - synchroniser flops, filtered outputs and drive delay lines load 1;
  - filter counters load 0;
  - start_det, stop_det, bus_busy, arb_lost, stretch load 0.
- Reset mid-transfer discards all state. bus_busy stays 0 until the next START.
- Synchroniser: SYNC_STG-flop chain per line.
- Filter, per line, using a counter of width clog2(FILT_CYC+1):
  - synchronised value equals filtered output: counter clears;
  - otherwise the counter increments;
  - when the counter reaches FILT_CYC-1 while still differing, the filtered output takes the new value and the counter clears.
  - Pulses shorter than FILT_CYC cycles are rejected.
  - Pad-to-sda_i/scl_i latency is exactly DLY cycles.
- Edge detection uses registered previous filtered values (sda_q, scl_q).
  - START: sda_q=1, sda_i=0, scl_q=1, scl_i=1.
  - STOP: sda_q=0, sda_i=1, scl_q=1, scl_i=1.
  - If SCL changes in the same cycle as SDA, neither condition is flagged.
  - start_det and stop_det are registered single-cycle pulses, asserted the cycle after the condition.
- bus_busy: set the cycle after START; cleared the cycle after STOP. A repeated START while busy pulses start_det and leaves busy at 1.
- Drive delay lines: sda_o and scl_o each pass through a DLY-stage shift register, giving sda_od and scl_od. These are the core's drive values aligned to the filtered input timing.
- arb_lost[k]:
  - set on a filtered SCL rising edge (scl_q=0, scl_i=1) when bus_busy=1, sda_od=1 and sda_i=0;
  - cleared by arb_clr;
  - if set and clear occur in the same cycle, set wins;
  - remains set across START/STOP.
- stretch[k]: registered value of (scl_od=1 AND scl_i=0). It is a level, not a pulse.
- Channels are fully independent. No shared state.

Test Plan:
- Reset: hold reset=0 for 3 cycles with pads pulled up → sda_i/scl_i=1, all flags 0. Drive sda_o=0 during reset → pad sda=0 immediately.
- Glitch filter (FILT_CYC=4, SYNC_STG=2):
  - external 3-cycle low pulse on SDA → sda_i stays 1;
  - 4-cycle low pulse → sda_i falls exactly 6 cycles after the pad falls.
- START/STOP: SCL high, drop SDA → start_det pulses once, bus_busy=1. Raise SDA with SCL high → stop_det pulses once, bus_busy=0. Toggle SDA and SCL in the same filtered cycle → no pulse.
- Arbitration:
  - ch0 busy, sda_o=1, external device holds SDA low, SCL released → arb_lost[0]=1 after the filtered SCL rise, stays 1;
  - arb_clr[0] pulse → 0;
  - arb_clr coincident with a new loss → stays 1.
- Stretch: scl_o=1 with external SCL held low 20 cycles → stretch=1 from DLY+1 cycles after release until DLY+1 cycles after the external release.
- Multi-channel (NUM_CH=2): START on ch1 only → ch0 start_det, bus_busy and sda_i unchanged. Reset asserted mid-transfer on ch1 → bus_busy[1]=0 until the next START.
